// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch for the multi-cycle core.
// Holds PC and IR and derives the sequential, branch and jump next-PC candidates.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pc_load,
  input  logic [31:0] new_pc,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [31:0] npc,
  output logic [31:0] bpc,
  output logic [31:0] jpc,
  output logic        align_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] fetch_count_r;
  logic        align_err_r;
  logic        req_s;
  logic        valid_s;
  logic        take_ack_s;
  logic        take_load_s;
  logic [31:0] npc_s;

  // Word-scaled, sign-extended 16-bit branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    logic [31:0] sext;
    sext = {{16{imm[15]}}, imm};
    return {sext[29:0], 2'b00};
  endfunction

  // Region-relative jump target: keeps the top nibble of the sequential PC.
  function automatic logic [31:0] jump_target(input logic [31:0] seq_pc, input logic [25:0] idx);
    return {seq_pc[31:28], idx, 2'b00};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (pc_load) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output and strobe decode; ack and load only count in their owning state.
  always_comb begin
    req_s       = 1'b0;
    valid_s     = 1'b0;
    take_ack_s  = 1'b0;
    take_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_s = 1'b0;
      end
      ST_REQ: begin
        req_s      = 1'b1;
        take_ack_s = imem_ack;
      end
      ST_HOLD: begin
        valid_s     = 1'b1;
        take_load_s = pc_load;
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
  end

  // PC, IR, fetch counter and sticky alignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      fetch_count_r <= 32'h0000_0000;
      align_err_r   <= 1'b0;
    end else begin
      if (take_ack_s) begin
        instr_r       <= imem_rdata;
        fetch_count_r <= fetch_count_r + 32'd1;
      end
      if (take_load_s) begin
        pc_r <= {new_pc[31:2], 2'b00};
        if (new_pc[1:0] != 2'b00) begin
          align_err_r <= 1'b1;
        end
      end
    end
  end

  assign npc_s       = pc_r + 32'd4;
  assign imem_req    = req_s;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_valid = valid_s;
  assign opcode      = instr_r[31:26];
  assign npc         = npc_s;
  assign bpc         = npc_s + branch_offset(instr_r[15:0]);
  assign jpc         = jump_target(npc_s, instr_r[25:0]);
  assign align_err   = align_err_r;
  assign fetch_count = fetch_count_r;

endmodule
